dm_port_arbiter: RTL

//  Shares the 16-word data memory between two requesters: the main pipeline (P) and the companion unit (C).

---
 rtl/dm_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing the data memory between the main pipeline (P) and the companion unit (C).
// Latency: DM access in the cycle after the accept edge; read data/err registered on the following edge.
// Backpressure: combinational grant; a requester holds its command while req && !gnt; one access per cycle.
module dm_port_arbiter #(
    parameter int NUM_WORDS = 16,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p_req,
    input  logic        p_we,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic        p_gnt,
    output logic        p_rvalid,
    output logic [31:0] p_rdata,
    output logic        p_err,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,

    output logic        dm_MemWr,
    output logic        dm_MemWrComp,
    output logic        dm_MemRd,
    output logic [31:0] dm_in,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_addr_c,
    input  logic [31:0] dm_out
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_P = 2'd1,
        ACC_C = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    state_t state, state_nxt;
    logic   last_owner;     // 0 = P served last, 1 = C served last
    logic   acc_we;
    logic   acc_err;
    logic   p_acc, c_acc;
    cmd_t   sel_cmd;
    logic   sel_fault;

    // Grant: sole requester wins; on a tie the one not served last wins.
    always_comb begin
        p_gnt = 1'b0;
        c_gnt = 1'b0;
        if (reset) begin
            if (p_req && c_req) begin
                if (last_owner) p_gnt = 1'b1;
                else            c_gnt = 1'b1;
            end else if (p_req) begin
                p_gnt = 1'b1;
            end else if (c_req) begin
                c_gnt = 1'b1;
            end
        end
    end

    assign p_acc = p_req && p_gnt;
    assign c_acc = c_req && c_gnt;

    always_comb begin
        sel_cmd = '0;
        if (p_acc) begin
            sel_cmd.we    = p_we;
            sel_cmd.addr  = p_addr;
            sel_cmd.wdata = p_wdata;
        end else if (c_acc) begin
            sel_cmd.we    = c_we;
            sel_cmd.addr  = c_addr;
            sel_cmd.wdata = c_wdata;
        end
    end

    assign sel_fault = (sel_cmd.addr[1:0] != 2'b00) || (sel_cmd.addr >= ADDR_LIMIT);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = IDLE;
        if (p_acc)      state_nxt = ACC_P;
        else if (c_acc) state_nxt = ACC_C;
    end

    // FSM outputs: DM enables for the access cycle; faulting accesses never touch the DM.
    always_comb begin
        dm_MemWr     = 1'b0;
        dm_MemWrComp = 1'b0;
        dm_MemRd     = 1'b0;
        if (state != IDLE && !acc_err) begin
            if (!acc_we)               dm_MemRd     = 1'b1;
            else if (state == ACC_P)   dm_MemWr     = 1'b1;
            else                       dm_MemWrComp = 1'b1;
        end
    end

    // Access registers; the DM address/data pins hold their last values while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_we     <= 1'b0;
            acc_err    <= 1'b0;
            dm_in      <= '0;
            dm_addr    <= '0;
            dm_addr_c  <= '0;
            last_owner <= ~PRIO_INIT;
        end else if (p_acc || c_acc) begin
            acc_we     <= sel_cmd.we;
            acc_err    <= sel_fault;
            last_owner <= c_acc;
            if (sel_cmd.we)
                dm_in <= sel_cmd.wdata;
            // C writes use their own address pin; everything else shares dm_addr.
            if (sel_cmd.we && c_acc)
                dm_addr_c <= sel_cmd.addr;
            else
                dm_addr <= sel_cmd.addr;
        end
    end

    // Responses on the edge that ends the access cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_rvalid <= 1'b0;
            p_err    <= 1'b0;
            p_rdata  <= '0;
            c_rvalid <= 1'b0;
            c_err    <= 1'b0;
            c_rdata  <= '0;
        end else begin
            p_rvalid <= (state == ACC_P) && !acc_we;
            p_err    <= (state == ACC_P) && acc_err;
            c_rvalid <= (state == ACC_C) && !acc_we;
            c_err    <= (state == ACC_C) && acc_err;
            if (state == ACC_P && !acc_we)
                p_rdata <= acc_err ? 32'd0 : dm_out;
            if (state == ACC_C && !acc_we)
                c_rdata <= acc_err ? 32'd0 : dm_out;
        end
    end

endmodule
